// File: rtl/sense_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sense_pkg                                                        |
// | Shared state type and defaults for the sense pulse controller.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package sense_pkg;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int CNT_W_DEF      = 8;
  localparam int DEB_W          = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    DRIVE    = 2'd2,
    BLANK    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sense_sync2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sense_sync2                                                      |
// | Two-flop synchroniser for a single asynchronous level.           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module sense_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sense_pulse_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sense_pulse_ctrl                                                 |
// | Debounces the comparator sense line, then drives the LED for a   |
// | programmable time followed by a blanking interval.               |
// | Optional event counter: define SENSE_EVT_CNT_EN.                 |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module sense_pulse_ctrl
  import sense_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             cmp_in,
  input  logic [CNT_W-1:0] on_time,
  input  logic [CNT_W-1:0] blank_time,
  input  logic             clr_cnt,
  output logic             led_en,
  output logic             evt_pulse,
  output logic             busy,
  output logic [7:0]       evt_cnt
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             cmp_s;
  state_t           state, state_nx;
  logic [DEB_W-1:0] deb_cnt, deb_cnt_nx;
  logic [CNT_W-1:0] timer, timer_nx;
  logic [CNT_W-1:0] on_load, blank_load;

  sense_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (cmp_in),
    .q   (cmp_s)
  );

  // A zero duration still yields one cycle, so the load value is max(x,1)-1.
  assign on_load    = (on_time    == '0) ? '0 : on_time    - CNT_W'(1);
  assign blank_load = (blank_time == '0) ? '0 : blank_time - CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      deb_cnt   <= '0;
      timer     <= '0;
      led_en    <= 1'b0;
      evt_pulse <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      deb_cnt   <= deb_cnt_nx;
      timer     <= timer_nx;
      led_en    <= (state_nx == DRIVE);
      evt_pulse <= (state == DEBOUNCE) && (state_nx == DRIVE);
      busy      <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx   = state;
    deb_cnt_nx = deb_cnt;
    timer_nx   = timer;
    if (!ena) begin
      state_nx   = IDLE;
      deb_cnt_nx = '0;
      timer_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmp_s) begin
            state_nx   = DEBOUNCE;
            deb_cnt_nx = '0;
          end
        end
        DEBOUNCE: begin
          if (!cmp_s) begin
            state_nx = IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            state_nx = DRIVE;
            timer_nx = on_load;
          end else begin
            deb_cnt_nx = deb_cnt + DEB_W'(1);
          end
        end
        DRIVE: begin
          if (timer == '0) begin
            state_nx = BLANK;
            timer_nx = blank_load;
          end else begin
            timer_nx = timer - CNT_W'(1);
          end
        end
        BLANK: begin
          if (timer == '0) begin
            state_nx = IDLE;
          end else begin
            timer_nx = timer - CNT_W'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

`ifdef SENSE_EVT_CNT_EN
  logic [7:0] evt_count;

  // Clear wins over a coincident event; the count sticks at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_count <= 8'd0;
    end else if (clr_cnt) begin
      evt_count <= 8'd0;
    end else if (evt_pulse && (evt_count != 8'hFF)) begin
      evt_count <= evt_count + 8'd1;
    end
  end

  assign evt_cnt = evt_count;
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign evt_cnt        = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sense_pulse_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sense_pulse_ctrl                                              |
// | Self-checking bench for sense_pulse_ctrl (DEB_CYCLES=4, CNT_W=8).|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_sense_pulse_ctrl;

  localparam int DEB = 4;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          cmp_in;
  logic          clr_cnt;
  logic [CW-1:0] on_time;
  logic [CW-1:0] blank_time;
  logic          led_en;
  logic          evt_pulse;
  logic          busy;
  logic [7:0]    evt_cnt;

  int checks   = 0;
  int failures = 0;
  int ev_total = 0;

  always #5 clk = ~clk;

  sense_pulse_ctrl #(
    .DEB_CYCLES (DEB),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .cmp_in     (cmp_in),
    .on_time    (on_time),
    .blank_time (blank_time),
    .clr_cnt    (clr_cnt),
    .led_en     (led_en),
    .evt_pulse  (evt_pulse),
    .busy       (busy),
    .evt_cnt    (evt_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_evt_cnt();
`ifdef SENSE_EVT_CNT_EN
    return (ev_total > 255) ? 8'd255 : 8'(ev_total);
`else
    return 8'd0;
`endif
  endfunction

  // Expected {led_en, evt_pulse, busy} after edge k, where edge 1 is the first
  // to sample cmp_in high. n>0: cmp_in high for n edges; n==0: held high.
  // An event needs DEB+1 high samples; the first DRIVE cycle follows edge DEB+3;
  // after DRIVE+BLANK the block idles one cycle before re-debouncing.
  function automatic logic [2:0] model(int k, int n, int on_e, int bl_e);
    int s1  = DEB + 3;
    int per = on_e + bl_e + 1 + DEB;
    int r;
    if (n > 0 && n < DEB + 1) return {1'b0, 1'b0, (k >= 3 && k <= n + 2)};
    if (k < 3) return 3'b000;
    if (k < s1) return 3'b001;
    r = k - s1;
    if (n > 0 && r >= on_e + bl_e) return 3'b000;
    r = r % per;
    return {(r < on_e), (r == 0), (r != on_e + bl_e)};
  endfunction

  task automatic run(input int n, input int nev, input int on_v, input int bl_v, input bit scramble);
    int on_e;
    int bl_e;
    int last;
    logic [2:0] e;
    on_e       = (on_v == 0) ? 1 : on_v;
    bl_e       = (bl_v == 0) ? 1 : bl_v;
    on_time    = CW'(on_v);
    blank_time = CW'(bl_v);
    cmp_in     = 1'b1;
    last = (n > 0) ? n + on_e + bl_e + DEB + 6 : DEB + 3 + (nev - 1) * (on_e + bl_e + 1 + DEB);
    for (int k = 1; k <= last; k++) begin
      step();
      if (n > 0 && k == n) cmp_in = 1'b0;
      if (scramble && k == DEB + 3) on_time = CW'($urandom);
      if (scramble && k == DEB + 3 + on_e) blank_time = CW'($urandom);
      e = model(k, n, on_e, bl_e);
      check($sformatf("out_n%0d_on%0d_bl%0d_k%0d", n, on_v, bl_v, k),
            {29'd0, led_en, evt_pulse, busy}, {29'd0, e});
      if (e[1]) ev_total++;
    end
    if (nev > 0) begin
      cmp_in = 1'b0;
      repeat (on_e + bl_e + DEB + 6) step();
    end
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_led", {31'd0, led_en}, 32'd0);
    check("evt_cnt", {24'd0, evt_cnt}, {24'd0, exp_evt_cnt()});
  endtask

  initial begin
    rst        = 1'b1;
    ena        = 1'b0;
    cmp_in     = 1'b0;
    clr_cnt    = 1'b0;
    on_time    = '0;
    blank_time = '0;
    step();
    step();
    check("rst_outputs", {28'd0, led_en, evt_pulse, busy, 1'b0}, 32'd0);
    check("rst_evt_cnt", {24'd0, evt_cnt}, 32'd0);
    rst = 1'b0;
    ena = 1'b1;
    repeat (3) step();

    run(0, 2, 10, 5, 1'b0);
    run(3, 0, 4, 4, 1'b0);
    run(DEB, 0, 4, 4, 1'b0);
    run(DEB + 1, 0, 3, 2, 1'b1);
    run(DEB + 2, 0, 0, 0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      run(int'($urandom_range(1, DEB + 3)), 0,
          int'($urandom_range(0, 12)), int'($urandom_range(0, 12)), 1'b1);
    end
    run(0, 3, int'($urandom_range(1, 6)), int'($urandom_range(0, 6)), 1'b0);

    run(0, 260, 0, 0, 1'b0);

    on_time    = 8'd3;
    blank_time = 8'd2;
    cmp_in     = 1'b1;
    repeat (DEB + 3) step();
    check("clr_evt_pulse", {31'd0, evt_pulse}, 32'd1);
    clr_cnt = 1'b1;
    step();
    clr_cnt  = 1'b0;
    ev_total = 0;
    check("clr_coincident", {24'd0, evt_cnt}, {24'd0, exp_evt_cnt()});
    cmp_in = 1'b0;
    repeat (12) step();
    check("clr_after", {24'd0, evt_cnt}, {24'd0, exp_evt_cnt()});

    on_time    = 8'd10;
    blank_time = 8'd5;
    cmp_in     = 1'b1;
    repeat (DEB + 3) step();
    ev_total++;
    repeat (2) step();
    check("ena_pre_led", {31'd0, led_en}, 32'd1);
    ena = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("ena_low_%0d", i), {29'd0, led_en, evt_pulse, busy}, 32'd0);
    end
    cmp_in = 1'b0;
    ena    = 1'b1;
    repeat (8) step();
    check("ena_idle_busy", {31'd0, busy}, 32'd0);
    check("ena_evt_cnt", {24'd0, evt_cnt}, {24'd0, exp_evt_cnt()});

    cmp_in = 1'b1;
    repeat (DEB + 4) step();
    check("rstmid_pre_led", {31'd0, led_en}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    ev_total = 0;
    check("rstmid_led", {31'd0, led_en}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_evt_cnt", {24'd0, evt_cnt}, 32'd0);
    cmp_in = 1'b0;
    step();
    rst = 1'b0;
    repeat (3) step();
    run(0, 1, 2, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
